// File: rtl/demux_1to8_32b_reg_pkg.sv
// Shared constants and helpers for the 1-to-8 registered demultiplexer.
//   DATA_W  : default width of each routed data word
//   NUM_CH  : number of output channels
//   SEL_W   : width of the channel select
//   CNT_W_DFLT : default width of the transfer counter
package demux_1to8_32b_reg_pkg;

  localparam int DATA_W     = 32;
  localparam int NUM_CH     = 8;
  localparam int SEL_W      = 3;
  localparam int CNT_W_DFLT = 16;

  typedef logic [SEL_W-1:0]  sel_t;
  typedef logic [NUM_CH-1:0] ch_mask_t;

  // Decode a channel number into a one-hot channel mask.
  function automatic ch_mask_t sel_onehot(input sel_t sel);
    ch_mask_t mask;
    mask      = '0;
    mask[sel] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/demux_chan_reg_32b.sv
// Single-entry holding register for one demux output channel.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   load, load_data: write a new word (wins over a simultaneous pop)
//   pop            : downstream ready; consumes the word when valid is high
//   data, valid    : held word and its valid flag
// The caller only asserts load when the entry is empty or being popped.
module demux_chan_reg_32b
  import demux_1to8_32b_reg_pkg::*;
#(
  parameter int DATA_W = demux_1to8_32b_reg_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  // NOTE: the data register is reset along with valid because the outputs
  // must read zero during reset; a pure datapath register would not need it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      // Load takes priority over pop, giving back-to-back flow with no bubble.
      data  <= load_data;
      valid <= 1'b1;
    end else if (pop && valid) begin
      // Data is left as-is after a pop; only the valid flag drops.
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1to8_32b_reg.sv
// 1-to-8 registered demultiplexer with per-channel valid/ready handshakes.
// Ports:
//   clock, reset_n       : clock and asynchronous active-low reset
//   in_data/in_sel       : word and destination channel offered upstream
//   in_valid/in_ready    : upstream handshake; in_ready depends only on the
//                          addressed channel's state, never on in_valid
//   out0..out7           : per-channel held data
//   out_valid/out_ready  : per-channel downstream handshakes
//   xfer_count           : number of accepted words since reset (wraps)
module demux_1to8_32b_reg
  import demux_1to8_32b_reg_pkg::*;
#(
  parameter int DATA_W = demux_1to8_32b_reg_pkg::DATA_W,
  parameter int CNT_W  = CNT_W_DFLT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic [DATA_W-1:0] out2,
  output logic [DATA_W-1:0] out3,
  output logic [DATA_W-1:0] out4,
  output logic [DATA_W-1:0] out5,
  output logic [DATA_W-1:0] out6,
  output logic [DATA_W-1:0] out7,
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [CNT_W-1:0]  xfer_count
);

  logic              accept;
  ch_mask_t          load_en;
  logic [DATA_W-1:0] chan_data [NUM_CH];

  // The addressed channel can take a word if it is empty or draining now;
  // a full, stalled channel blocks only words addressed to it.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  assign accept   = in_valid && in_ready;

  // NOTE: every signal driven in always_comb gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    load_en = '0;
    if (accept) begin
      load_en = sel_onehot(in_sel);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    demux_chan_reg_32b #(
      .DATA_W(DATA_W)
    ) u_chan (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load_en[k]),
      .load_data(in_data),
      .pop      (out_ready[k]),
      .data     (chan_data[k]),
      .valid    (out_valid[k])
    );
  end

  // Free-running accept counter; natural binary overflow gives the wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      xfer_count <= '0;
    end else if (accept) begin
      xfer_count <= xfer_count + CNT_W'(1);
    end
  end

  assign out0 = chan_data[0];
  assign out1 = chan_data[1];
  assign out2 = chan_data[2];
  assign out3 = chan_data[3];
  assign out4 = chan_data[4];
  assign out5 = chan_data[5];
  assign out6 = chan_data[6];
  assign out7 = chan_data[7];

endmodule

// File: tb/tb_demux_1to8_32b_reg.sv
// Self-checking bench for demux_1to8_32b_reg: directed vector table,
// hand-written reset/sweep/wrap sequences, and randomized traffic checked
// against a channel-occupancy reference model.
module tb_demux_1to8_32b_reg;

  logic        clock;
  logic        reset_n;
  logic [31:0] in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out0, out1, out2, out3, out4, out5, out6, out7;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;
  logic [15:0] xfer_count;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1to8_32b_reg #(
    .DATA_W(32),
    .CNT_W (16)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out5      (out5),
    .out6      (out6),
    .out7      (out7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_count(xfer_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Each channel is a box holding 0 or 1 words; last_word remembers what
  // the output shows even after the word has been consumed.
  int          occ       [8];
  logic [31:0] last_word [8];
  int unsigned accepted;

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      occ[k]       = 0;
      last_word[k] = 32'h0;
    end
    accepted = 0;
  endtask

  function automatic logic model_ready(input logic [2:0] sel, input logic [7:0] ordy);
    return (occ[sel] == 0) || ordy[sel];
  endfunction

  task automatic model_cycle(input logic [31:0] d, input logic [2:0] sel,
                             input logic v, input logic [7:0] ordy);
    logic acc;
    acc = v && model_ready(sel, ordy);
    for (int k = 0; k < 8; k++)
      if (occ[k] > 0 && ordy[k]) occ[k] = occ[k] - 1;
    if (acc) begin
      occ[sel]       = occ[sel] + 1;
      last_word[sel] = d;
      accepted       = accepted + 1;
    end
  endtask

  function automatic logic [7:0] model_valid();
    logic [7:0] m;
    for (int k = 0; k < 8; k++) m[k] = (occ[k] > 0);
    return m;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [31:0] dut_out(input int k);
    case (k)
      0: return out0;
      1: return out1;
      2: return out2;
      3: return out3;
      4: return out4;
      5: return out5;
      6: return out6;
      default: return out7;
    endcase
  endfunction

  task automatic drive(input logic [31:0] d, input logic [2:0] sel,
                       input logic v, input logic [7:0] ordy);
    in_data   = d;
    in_sel    = sel;
    in_valid  = v;
    out_ready = ordy;
    #1;
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(32'h0, 3'd0, 1'b0, 8'h00);
    step();
    step();
    reset_n = 1'b1;
    #1;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] data;
    logic [2:0]  sel;
    logic        vld;
    logic [7:0]  ordy;
    logic        exp_ready;
    logic [7:0]  exp_ov;
    logic [15:0] exp_cnt;
    logic [2:0]  chk_ch;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // routing, back-pressure, other-channel load, pop+load, pop hold, drain
    vecs[0] = '{32'hDEADBEEF, 3'd5, 1'b1, 8'h00, 1'b1, 8'h20, 16'd1, 3'd5, 32'hDEADBEEF};
    vecs[1] = '{32'h11111111, 3'd5, 1'b1, 8'h00, 1'b0, 8'h20, 16'd1, 3'd5, 32'hDEADBEEF};
    vecs[2] = '{32'h22222222, 3'd2, 1'b1, 8'h00, 1'b1, 8'h24, 16'd2, 3'd2, 32'h22222222};
    vecs[3] = '{32'h00000001, 3'd3, 1'b1, 8'h00, 1'b1, 8'h2C, 16'd3, 3'd3, 32'h00000001};
    vecs[4] = '{32'h00000002, 3'd3, 1'b1, 8'h08, 1'b1, 8'h2C, 16'd4, 3'd3, 32'h00000002};
    vecs[5] = '{32'h99999999, 3'd3, 1'b0, 8'h08, 1'b1, 8'h24, 16'd4, 3'd3, 32'h00000002};
    vecs[6] = '{32'h77777777, 3'd0, 1'b0, 8'hFF, 1'b1, 8'h00, 16'd4, 3'd5, 32'hDEADBEEF};

    reset_n   = 1'b0;
    in_data   = '0;
    in_sel    = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    #2;
    check("reset_out_valid", out_valid, 8'h00);
    check("reset_count", xfer_count, 16'h0);
    check("reset_in_ready", in_ready, 1'b1);
    do_reset();

    // ---- table ----
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].data, vecs[i].sel, vecs[i].vld, vecs[i].ordy);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_ready);
      step();
      check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      check($sformatf("vec%0d_count", i), xfer_count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_out%0d", i, vecs[i].chk_ch), dut_out(vecs[i].chk_ch), vecs[i].exp_word);
    end

    // ---- full sweep: 8 words to sel 0..7, nothing drains ----
    for (int i = 0; i < 8; i++) begin
      drive(32'hA0000000 + 32'(i), 3'(i), 1'b1, 8'h00);
      check($sformatf("sweep%0d_in_ready", i), in_ready, 1'b1);
      step();
    end
    check("sweep_out_valid", out_valid, 8'hFF);
    check("sweep_count", xfer_count, 16'd12);
    for (int i = 0; i < 8; i++) begin
      drive(32'hBAD00000, 3'(i), 1'b1, 8'h00);
      check($sformatf("ninth_sel%0d_in_ready", i), in_ready, 1'b0);
      check($sformatf("sweep_out%0d", i), dut_out(i), 32'hA0000000 + 32'(i));
    end

    // ---- reset mid-traffic, with a word offered across the reset edge ----
    drive(32'hCAFEF00D, 3'd1, 1'b1, 8'h02);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 8'h00);
    check("midreset_count", xfer_count, 16'h0);
    for (int k = 0; k < 8; k++)
      check($sformatf("midreset_out%0d", k), dut_out(k), 32'h0);
    step();
    check("midreset_hold_valid", out_valid, 8'h00);
    check("midreset_hold_out1", out1, 32'h0);
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 8; k++) begin
      drive(32'h0, 3'(k), 1'b0, 8'h00);
      check($sformatf("release_sel%0d_in_ready", k), in_ready, 1'b1);
    end
    // First edge after release must already accept.
    drive(32'h12345678, 3'd6, 1'b1, 8'h00);
    step();
    model_cycle(32'h12345678, 3'd6, 1'b1, 8'h00);
    check("release_first_out_valid", out_valid, 8'h40);
    check("release_first_out6", out6, 32'h12345678);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 400; c++) begin
      logic [31:0] d;
      logic [2:0]  s;
      logic        v;
      logic [7:0]  r;
      d = $urandom;
      s = 3'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) != 0);
      r = 8'($urandom) & 8'($urandom);
      drive(d, s, v, r);
      check("rand_in_ready", in_ready, model_ready(s, r));
      step();
      model_cycle(d, s, v, r);
      check("rand_out_valid", out_valid, model_valid());
      check("rand_count", xfer_count, 16'(accepted));
      for (int k = 0; k < 8; k++)
        check($sformatf("rand_out%0d", k), dut_out(k), last_word[k]);
    end

    // ---- counter wrap: 65536 accepts after reset ----
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      drive(32'(i), 3'(i), 1'b1, 8'hFF);
      step();
    end
    check("wrap_count_ffff", xfer_count, 16'hFFFF);
    drive(32'h5A5A5A5A, 3'd7, 1'b1, 8'hFF);
    check("wrap_in_ready", in_ready, 1'b1);
    step();
    check("wrap_count_zero", xfer_count, 16'h0000);
    check("wrap_last_out7", out7, 32'h5A5A5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1to8_32b_reg.md
DEMUX_1TO8_32B_REG -- requirements
Module: demux_1to8_32b_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of each data word.
REQ-002 SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_data  input  DATA_W  word to route.
REQ-006 SHALL have port in_sel  input  3  destination channel 0..7.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data/in_sel.
REQ-008 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-009 SHALL have ports out0..out7  output  DATA_W each  per-channel held data.
REQ-010 SHALL have port out_valid  output  8  bit k: out<k> holds an undelivered word.
REQ-011 SHALL have port out_ready  input  8  bit k: downstream k consumes out<k> this cycle.
REQ-012 SHALL have port xfer_count  output  CNT_W  total words accepted since reset.

Function
REQ-013 SHALL define accept = in_valid AND in_ready, and pop_k = out_valid[k] AND out_ready[k].
REQ-014 SHALL drive in_ready combinationally as NOT out_valid[in_sel] OR out_ready[in_sel]; in_ready SHALL NOT depend on in_valid.
REQ-015 SHALL, on accept, load in_data into out<in_sel> and set out_valid[in_sel] to 1 at the next edge (latency 1 cycle).
REQ-016 SHALL clear out_valid[k] at the next edge on pop_k when channel k is not simultaneously loaded.
REQ-017 SHALL, on pop_k and accept to channel k in the same cycle, keep out_valid[k] at 1 and load the new word (no bubble).
REQ-018 SHALL hold out<k> stable while out_valid[k]=1 and out_ready[k]=0.
REQ-019 SHALL leave out<k> unchanged after a pop until the next load into channel k; downstream SHALL ignore out<k> while out_valid[k]=0.
REQ-020 SHALL leave channels other than in_sel unaffected by an accept; each channel SHALL process pops independently, with up to 8 pops in one cycle.
REQ-021 SHALL sample in_sel and in_data only on accept; values without accept SHALL have no effect.
REQ-022 SHALL increment xfer_count by 1 per accept, wrapping from all-ones to 0.
REQ-023 SHALL hold at most one word per channel; a full channel with out_ready low SHALL back-pressure only words addressed to it.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force out_valid=8'h00, out0..out7=0, and xfer_count=0.
REQ-025 SHALL discard words held at reset assertion, including a word accepted in the same cycle reset asserts; no partial state SHALL survive.
REQ-026 SHALL resume operation on the first rising clock edge after reset_n deasserts; in_ready SHALL be 1 for any in_sel once out_valid=0.

Structure
REQ-027 SHALL take the constants DATA_W=32, NUM_CH=8 and SEL_W=3 from the shared package alongside the mux widths.
REQ-028 SHALL use one sub-module, demux_chan_reg_32b (a single-entry data/valid holding register with load and pop), instantiated 8 times.
REQ-029 SHALL decode in_sel to the one-hot load enables and select out_valid/out_ready for in_ready in the top level, not in the sub-module.

Verification
REQ-030 SHALL cover reset: reset_n=0 mid-traffic with out_valid=8'hFF -> out_valid=0, outputs=0 and xfer_count=0 immediately; in_ready=1 after release.
REQ-031 SHALL cover basic routing: in_data=32'hDEADBEEF, in_sel=5, in_valid=1, out_ready=0 -> next cycle out5=32'hDEADBEEF, out_valid=8'h20, xfer_count=1.
REQ-032 SHALL cover back-pressure: channel 5 full with out_ready[5]=0, in_sel=5 -> in_ready=0 and out5 unchanged; in_sel=2 in the same state -> in_ready=1 and out2 loaded.
REQ-033 SHALL cover simultaneous pop and load: channel 3 holding 32'h1, out_ready[3]=1, new word 32'h2 to sel 3 -> out_valid[3] stays 1 and out3=32'h2 next cycle.
REQ-034 SHALL cover counter wrap: 65536 accepts after reset -> xfer_count returns to 16'h0000.
REQ-035 SHALL cover a full sweep: 8 back-to-back words to sel 0..7 with all out_ready=0 -> out_valid=8'hFF after 8 cycles; a ninth word to any sel -> in_ready=0.
